// File: rtl/seq_adder.sv
// seq_adder: multi-cycle adder processing SLICE bits per cycle; SEQ_ADDER_SUB_EN adds a subtract port
module seq_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);
  localparam int K = WIDTH / SLICE;
  localparam int IW = K > 1 ? $clog2(K) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] op_a, op_b, acc, nxt, b_eff;
  logic [IW-1:0] idx;
  logic [SLICE:0] sum;
  logic carry, cin_eff, last;
`ifdef SEQ_ADDER_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign cin_eff = sub | c_in;
`else
  assign b_eff = b;
  assign cin_eff = c_in;
`endif
  always_comb begin
    sum = {1'b0, op_a[idx*SLICE +: SLICE]} + {1'b0, op_b[idx*SLICE +: SLICE]} + {{SLICE{1'b0}}, carry};
    nxt = acc;
    nxt[idx*SLICE +: SLICE] = sum[SLICE-1:0];
    last = idx == IW'(K - 1);
  end
  // ovf uses a^b^s at the MSB to recover the carry into bit WIDTH-1
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      idx   <= '0;
      carry <= 1'b0;
    end else if (state == RUN) begin
      acc   <= nxt;
      carry <= sum[SLICE];
      idx   <= idx + 1'b1;
      if (last) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        s     <= nxt;
        c_out <= sum[SLICE];
        ovf   <= op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ nxt[WIDTH-1] ^ sum[SLICE];
      end
    end else begin
      done <= 1'b0;
      if (start) begin
        op_a  <= a;
        op_b  <= b_eff;
        carry <= cin_eff;
        idx   <= '0;
        state <= RUN;
        busy  <= 1'b1;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: randomized self-checking bench for seq_adder against an arithmetic reference model
module tb_seq_adder;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, c_in = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, c_out, ovf;
  logic [W-1:0] s;
  int cmp = 0, err = 0;

  always #5 clk = ~clk;

  seq_adder #(.WIDTH(W), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
`ifdef SEQ_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .s(s), .c_out(c_out), .ovf(ovf)
  );

  // returns {ovf, c_out, s}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    logic [W-1:0] yy;
    logic cc;
    logic [W:0] t;
    logic v;
    yy = sb ? ~y : y;
    cc = sb ? 1'b1 : ci;
    t = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    v = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {v, t};
  endfunction

  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts,
                        output int lat, output int bcnt, output bit chg);
    logic [W-1:0] s0;
    @(negedge clk);
    a = ta; b = tb; c_in = tc; sub = ts; start = 1'b1;
    s0 = s;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bcnt = 0; chg = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      if (s !== s0) chg = 1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h4321;
    repeat (2) @(posedge clk);
    #1;
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b exp 0", busy); end
    cmp++; if (done !== 1'b0) begin err++; $display("FAIL reset_done: got %b exp 0", done); end
    cmp++; if (s !== '0) begin err++; $display("FAIL reset_s: got %h exp 0000", s); end
    cmp++; if (c_out !== 1'b0) begin err++; $display("FAIL reset_cout: got %b exp 0", c_out); end
    cmp++; if (ovf !== 1'b0) begin err++; $display("FAIL reset_ovf: got %b exp 0", ovf); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_directed;
    int lat, bcnt;
    bit chg;
    launch(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat, bcnt, chg);
    cmp++; if (lat != 5) begin err++; $display("FAIL d1_latency: got %0d exp 5", lat); end
    cmp++; if (bcnt != 4) begin err++; $display("FAIL d1_busy_cycles: got %0d exp 4", bcnt); end
    cmp++; if ({ovf, c_out, s} !== {1'b0, 1'b1, 16'h0000}) begin err++; $display("FAIL d1_result: got %h exp %h", {ovf, c_out, s}, {1'b0, 1'b1, 16'h0000}); end
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL d1_busy_in_done: got %b exp 0", busy); end
    launch(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bcnt, chg);
    cmp++; if (chg != 0) begin err++; $display("FAIL d2_partial_s: got %0d exp 0", chg); end
    cmp++; if ({ovf, c_out, s} !== {1'b1, 1'b0, 16'h8000}) begin err++; $display("FAIL d2_result: got %h exp %h", {ovf, c_out, s}, {1'b1, 1'b0, 16'h8000}); end
    @(posedge clk); #1;
    cmp++; if (done !== 1'b0) begin err++; $display("FAIL d2_done_pulse: got %b exp 0", done); end
    cmp++; if (s !== 16'h8000) begin err++; $display("FAIL d2_s_hold: got %h exp 8000", s); end
  endtask

  task automatic test_random;
    int lat, bcnt;
    bit chg;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    logic [W+1:0] exp;
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef SEQ_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (i == 0) begin ra = 16'h8000; rb = 16'h8000; end
      exp = model(ra, rb, rc, rs);
      launch(ra, rb, rc, rs, lat, bcnt, chg);
      cmp++; if ({ovf, c_out, s} !== exp) begin err++; $display("FAIL rand_result[%0d]: got %h exp %h", i, {ovf, c_out, s}, exp); end
      cmp++; if (lat != 5) begin err++; $display("FAIL rand_latency[%0d]: got %0d exp 5", i, lat); end
      cmp++; if (bcnt != 4) begin err++; $display("FAIL rand_busy[%0d]: got %0d exp 4", i, bcnt); end
      cmp++; if (chg != 0) begin err++; $display("FAIL rand_partial_s[%0d]: got %0d exp 0", i, chg); end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] na, nb;
    logic nc;
    logic [W+1:0] exp;
    int n;
    @(negedge clk);
    na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
    a = na; b = nb; c_in = nc; sub = 1'b0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp = model(na, nb, nc, 1'b0);
      a = ~na; b = W'($urandom); c_in = ~nc;
      n = 1;
      while (!done && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      cmp++; if (n != 5) begin err++; $display("FAIL b2b_period[%0d]: got %0d exp 5", i, n); end
      cmp++; if ({ovf, c_out, s} !== exp) begin err++; $display("FAIL b2b_result[%0d]: got %h exp %h", i, {ovf, c_out, s}, exp); end
      na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
      a = na; b = nb; c_in = nc;
    end
    start = 1'b0;
    @(posedge clk); #1;
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL b2b_idle: got %b exp 0", busy); end
  endtask

  task automatic test_reset_abort;
    int lat, bcnt;
    bit chg, seen;
    logic [W+1:0] exp;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL abort_busy: got %b exp 0", busy); end
    cmp++; if (s !== '0) begin err++; $display("FAIL abort_s: got %h exp 0000", s); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    cmp++; if (seen != 0) begin err++; $display("FAIL abort_no_done: got %0d exp 0", seen); end
    exp = model(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
    launch(16'h0F0F, 16'h00F1, 1'b1, 1'b0, lat, bcnt, chg);
    cmp++; if ({ovf, c_out, s} !== exp) begin err++; $display("FAIL abort_recover: got %h exp %h", {ovf, c_out, s}, exp); end
    cmp++; if (lat != 5) begin err++; $display("FAIL abort_latency: got %0d exp 5", lat); end
  endtask

`ifdef SEQ_ADDER_SUB_EN
  task automatic test_sub;
    int lat, bcnt;
    bit chg;
    launch(16'h0005, 16'h0007, 1'b1, 1'b1, lat, bcnt, chg);
    cmp++; if ({ovf, c_out, s} !== {1'b0, 1'b0, 16'hFFFE}) begin err++; $display("FAIL sub1: got %h exp %h", {ovf, c_out, s}, {1'b0, 1'b0, 16'hFFFE}); end
    launch(16'h8000, 16'h0001, 1'b0, 1'b1, lat, bcnt, chg);
    cmp++; if ({ovf, c_out, s} !== {1'b1, 1'b1, 16'h7FFF}) begin err++; $display("FAIL sub2: got %h exp %h", {ovf, c_out, s}, {1'b1, 1'b1, 16'h7FFF}); end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_abort;
`ifdef SEQ_ADDER_SUB_EN
    test_sub;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits, legal range 4..64.
REQ-002 SHALL have parameter SLICE, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of SLICE; K = WIDTH/SLICE.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request an add; sampled only when busy=0.
REQ-006 SHALL have ports a, b  input  WIDTH  operands, captured on the edge that accepts start.
REQ-007 SHALL have port c_in  input  1  carry-in, captured with a and b.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-010 SHALL have port s  output  WIDTH  registered sum.
REQ-011 SHALL have port c_out  output  1  carry out of bit WIDTH-1.
REQ-012 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-014 IDLE: busy=0, done=0; start=1 captures a, b, c_in, clears slice counter, goes to RUN.
REQ-015 RUN: each cycle adds slice idx (bits idx*SLICE+SLICE-1 .. idx*SLICE) of the captured operands plus the carry register, stores the partial sum in an internal result register, updates the carry, and increments idx.
REQ-016 RUN SHALL last exactly K cycles; after the edge processing slice K-1 the FSM goes to DONE.
REQ-017 On the RUN-to-DONE edge, s, c_out and ovf SHALL be loaded from the internal result; done=1 for exactly the DONE cycle; busy=1 in RUN only.
REQ-018 Latency: done SHALL assert in the cycle after the (K+1)-th rising edge counted from, and including, the edge that samples start.
REQ-019 DONE SHALL return to IDLE on the next edge; start asserted during DONE SHALL be accepted (busy=0), going directly to RUN for back-to-back operation.
REQ-020 start while busy=1 SHALL be ignored; captured operands SHALL NOT change.
REQ-021 s, c_out and ovf SHALL hold their last value until the next DONE load; they SHALL NOT show partial sums.
REQ-022 ovf SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-023 Result SHALL equal (a + b + c_in) mod 2^WIDTH, with c_out the bit-WIDTH carry.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, s=0, c_out=0, ovf=0, counter and carry cleared.
REQ-025 rst SHALL take priority over start and SHALL abort an operation in RUN or DONE without producing done.

Configuration
REQ-026 Macro SEQ_ADDER_SUB_EN SHALL, when defined, add port sub  input  1, captured with a and b.
REQ-027 With SEQ_ADDER_SUB_EN and sub=1: b SHALL be bitwise inverted and carry-in forced to 1 (c_in ignored), giving a - b; c_out=1 means no borrow; ovf per REQ-022.
REQ-028 Without SEQ_ADDER_SUB_EN: no sub port; behaviour is addition only.

Verification (WIDTH=16, SLICE=4, K=4)
REQ-029 a=0xFFFF, b=0x0000, c_in=1, start pulse -> done 5 edges later, s=0x0000, c_out=1, ovf=0; busy high for exactly 4 cycles.
REQ-030 a=0x7FFF, b=0x0001, c_in=0 -> s=0x8000, c_out=0, ovf=1; s shows the previous result until done.
REQ-031 start held high continuously with new operands each accept -> done every 5 cycles; second start during RUN ignored (operands unchanged, result from first capture).
REQ-032 rst asserted during the 2nd RUN cycle -> next cycle busy=0, s=0, no done pulse; a following start=1 completes normally.
REQ-033 SEQ_ADDER_SUB_EN defined, a=0x0005, b=0x0007, sub=1, c_in=1 -> s=0xFFFE, c_out=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, c_out=1, ovf=1.
